// File: rtl/pwm_channel_pkg.sv
// Shared constants and helpers for the PWM channel and its prescaler.
// The default WIDTH/CLK_DIV live here so the rgb mixer can reuse them.
package pwm_channel_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CLK_DIV = 1;

    // A divide-by-1 prescaler still keeps a one-bit counter so the port list never collapses.
    function automatic int div_cnt_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits one tick every CLK_DIV enabled clk cycles.
module pwm_prescaler
    import pwm_channel_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int            DW   = div_cnt_width(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    assign tick = en && (div_cnt_q == LAST);

    // Disabling clears the phase so a re-enabled channel starts on a clean tick boundary.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_channel.sv
// One LED colour PWM channel: period counter, shadow duty register and compare.
// Build option PWM_GAMMA_EN selects a square-law duty curve instead of a linear one.
module pwm_channel
    import pwm_channel_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] duty_active
);

    localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LAST_CNT = {{(WIDTH-1){1'b1}}, 1'b0};

`ifdef PWM_GAMMA_EN
    // (d*d + MAX) >> WIDTH: rounds so that 0 and MAX map onto themselves.
    function automatic logic [WIDTH-1:0] map_level(input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] sq;
        sq = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d} + {{WIDTH{1'b0}}, MAX};
        return sq[2*WIDTH-1:WIDTH];
    endfunction
`else
    function automatic logic [WIDTH-1:0] map_level(input logic [WIDTH-1:0] d);
        return d;
    endfunction
`endif

    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_active_q;
    logic [WIDTH-1:0] duty_active_d;
    logic             pwm_out_q;
    logic             pwm_out_d;
    logic             period_start_q;
    logic             period_start_d;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .tick    (tick)
    );

    assign wrap = tick && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // The shadow only follows duty at a wrap, or continuously while idle so the
    // first enabled period already uses the requested level.
    always_comb begin
        duty_active_d = duty_active_q;
        if (!en || wrap) begin
            duty_active_d = map_level(duty);
        end
    end

    always_comb begin
        pwm_out_d      = en && (cnt_q < duty_active_q);
        period_start_d = wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            duty_active_q  <= '0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_active_q  <= duty_active_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_channel.sv
// Self-checking bench for pwm_channel (CLK_DIV=1 and CLK_DIV=4 instances).
module tb_pwm_channel;

    localparam int MAXV = 255;
    localparam int NRAND = 800;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [7:0] duty;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;
    logic       en4;
    logic [7:0] duty4;
    logic       pwm4;
    logic       ps4;
    logic [7:0] da4;

    int total;
    int bad;

    pwm_channel #(.WIDTH(8), .CLK_DIV(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    pwm_channel #(.WIDTH(8), .CLK_DIV(4)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en4),
        .duty         (duty4),
        .pwm_out      (pwm4),
        .period_start (ps4),
        .duty_active  (da4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference curve
    function automatic int ref_map(input int d);
`ifdef PWM_GAMMA_EN
        return (d * d + MAXV) >> 8;
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_main(input int n, output int highs, output int starts);
        highs = 0;
        starts = 0;
        for (int i = 0; i < n; i++) begin
            step();
            highs += int'(pwm_out);
            starts += int'(period_start);
        end
    endtask

    task automatic preload(input int d);
        en = 1'b0;
        duty = 8'(d);
        step();
    endtask

    typedef struct {
        logic en;
        int   duty;
        int   n;
        int   exp_high;
        int   exp_starts;
    } vec_t;

    vec_t vecs[7];
    int   duty_at[NRAND+1];

    initial begin
        int h, s, h1, h2, h3, s2, lvl, p0;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        en = 1'b0;
        duty = 8'd0;
        en4 = 1'b0;
        duty4 = 8'd0;
        step();
        step();
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_ps", int'(period_start), 0);
        check("reset_da", int'(duty_active), 0);
        reset_n = 1'b1;

        // table-driven whole-period vectors
        vecs[0] = '{1'b1, 64, 765, 3 * ref_map(64), 3};
        vecs[1] = '{1'b1, 0, 765, 0, 3};
        vecs[2] = '{1'b1, 255, 765, 765, 3};
        vecs[3] = '{1'b1, 1, 510, 2 * ref_map(1), 2};
        vecs[4] = '{1'b1, 254, 510, 2 * ref_map(254), 2};
        vecs[5] = '{1'b0, 200, 300, 0, 0};
        vecs[6] = '{1'b1, 128, 255, ref_map(128), 1};
        for (int v = 0; v < 7; v++) begin
            preload(vecs[v].duty);
            check($sformatf("v%0d_preload", v), int'(duty_active), ref_map(vecs[v].duty));
            en = vecs[v].en;
            run_main(vecs[v].n, h, s);
            check($sformatf("v%0d_high", v), h, vecs[v].exp_high);
            check($sformatf("v%0d_starts", v), s, vecs[v].exp_starts);
        end

        preload(128);
        check("gamma128", int'(duty_active), ref_map(128));

        // async reset mid-run, then first period after release
        preload(255);
        en = 1'b1;
        run_main(100, h, s);
        check("pre_reset_pwm", int'(pwm_out), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_pwm", int'(pwm_out), 0);
        check("async_ps", int'(period_start), 0);
        check("async_da", int'(duty_active), 0);
        step();
        reset_n = 1'b1;
        run_main(254, h, s);
        check("post_reset_high", h, 0);
        check("post_reset_starts", s, 0);
        step();
        check("post_reset_wrap_ps", int'(period_start), 1);
        check("post_reset_wrap_da", int'(duty_active), 255);
        run_main(255, h, s);
        check("post_reset_p2_high", h, 255);

        // duty change mid-period takes effect only at the next wrap
        preload(64);
        en = 1'b1;
        run_main(100, h1, s);
        duty = 8'd200;
        run_main(154, h2, s2);
        check("midchg_no_start", s + s2, 0);
        check("midchg_da_hold", int'(duty_active), ref_map(64));
        step();
        h3 = int'(pwm_out);
        check("midchg_ps", int'(period_start), 1);
        check("midchg_da_new", int'(duty_active), ref_map(200));
        check("midchg_p1_high", h1 + h2 + h3, ref_map(64));
        run_main(255, h, s);
        check("midchg_p2_high", h, ref_map(200));
        check("midchg_p2_starts", s, 1);

        // enable dropped mid-period, then re-enabled
        preload(64);
        en = 1'b1;
        run_main(30, h, s);
        check("drop_pre_pwm", int'(pwm_out), 1);
        en = 1'b0;
        step();
        check("drop_pwm", int'(pwm_out), 0);
        check("drop_ps", int'(period_start), 0);
        en = 1'b1;
        run_main(254, h1, s);
        check("reen_no_start", s, 0);
        step();
        check("reen_wrap_ps", int'(period_start), 1);
        check("reen_high", h1 + int'(pwm_out), ref_map(64));

        // CLK_DIV=4 instance
        en4 = 1'b0;
        duty4 = 8'd10;
        step();
        check("div4_preload", int'(da4), ref_map(10));
        en4 = 1'b1;
        h = 0;
        s = 0;
        for (int i = 0; i < 1019; i++) begin
            step();
            h += int'(pwm4);
            s += int'(ps4);
        end
        check("div4_no_early_start", s, 0);
        step();
        h += int'(pwm4);
        check("div4_wrap_ps", int'(ps4), 1);
        check("div4_high", h, 4 * ref_map(10));
        en4 = 1'b0;

        // random duty changes against an arithmetic period model
        duty_at[0] = int'($urandom_range(0, 255));
        preload(duty_at[0]);
        en = 1'b1;
        for (int n = 1; n <= NRAND; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: duty = 8'd0;
                    1: duty = 8'd255;
                    default: duty = 8'($urandom_range(0, 255));
                endcase
            end
            duty_at[n] = int'(duty);
            step();
            p0 = 255 * ((n - 1) / 255);
            lvl = ref_map(duty_at[p0]);
            check($sformatf("rnd_pwm@%0d", n), int'(pwm_out), (((n - 1) % 255) < lvl) ? 1 : 0);
            check($sformatf("rnd_ps@%0d", n), int'(period_start), (n % 255 == 0) ? 1 : 0);
            check($sformatf("rnd_da@%0d", n), int'(duty_active), ref_map(duty_at[255 * (n / 255)]));
        end
        en = 1'b0;
        step();

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
